fpga_obuf_bank: RTL and testbench
=================================

FPGA_OBUF_BANK -- requirements
Module: fpga_obuf_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of output channels (legal 1..64).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, meaning the post-reset safe-hold duration in clk cycles (legal 1..65535).
REQ-003 SHALL have parameter SAFE_VAL, WIDTH bits, default all-zero, meaning the pad value driven whenever the bank is not active.
REQ-004 SHALL have parameter INV_MASK, WIDTH bits, default all-zero, meaning per-channel output inversion (1 = inverted), applied to the data path only.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 i  input  WIDTH  core data to be driven to the pads.
REQ-008 en  input  1  request to drive core data (level).
REQ-009 freeze  input  1  when high in ACTIVE, the output register holds its value.
REQ-010 o  output  WIDTH  pad-side outputs, each through one technology output buffer.
REQ-011 active  output  1  high while the bank is in ACTIVE.
REQ-012 hold_busy  output  1  high while the bank is in HOLD.

Function
REQ-013 The FSM SHALL have states HOLD, IDLE and ACTIVE, with an encoding of 2 bits.
REQ-014 HOLD: the bank SHALL drive SAFE_VAL and increment a hold counter each cycle; it SHALL go to IDLE on the cycle the counter reaches HOLD_CYCLES-1; en SHALL be ignored in HOLD.
REQ-015 IDLE: the bank SHALL drive SAFE_VAL; it SHALL go to ACTIVE on the first clk edge that samples en=1.
REQ-016 ACTIVE: on each edge with freeze=0, the output register SHALL load i XOR INV_MASK; with freeze=1 the register SHALL hold.
REQ-017 ACTIVE to IDLE: on an edge that samples en=0, the output register SHALL load SAFE_VAL on that same edge, irrespective of freeze.
REQ-018 Latency from i to o SHALL be exactly 1 clk cycle in ACTIVE; the first core word SHALL appear on the cycle after the IDLE-to-ACTIVE edge.
REQ-019 On the IDLE-to-ACTIVE edge, the register SHALL load i XOR INV_MASK (unless freeze=1, in which case it SHALL keep SAFE_VAL).
REQ-020 The hold counter SHALL be 16 bits wide, SHALL saturate and never wrap, and SHALL be inert outside HOLD.
REQ-021 o SHALL be driven only from a flop, with no combinational path from any input to o.
REQ-022 active and hold_busy SHALL be registered decodes of the FSM state, and SHALL be valid in the same cycle as the state.
REQ-023 If en and freeze both toggle on the same edge, REQ-017 SHALL take priority over REQ-016.

Reset
REQ-024 When rst is asserted, it SHALL asynchronously force state=HOLD, the hold counter to 0, the output register to SAFE_VAL, active=0 and hold_busy=1.
REQ-025 Deassertion of rst SHALL be synchronised to clk externally; the first counting edge SHALL be the first edge with rst=0.
REQ-026 Reset asserted mid-ACTIVE SHALL return the pads to SAFE_VAL immediately, without waiting for a clk edge, and SHALL restart the full HOLD sequence.

Structure
REQ-027 The state enum and the hold-counter width constant (16) SHALL reside in shared package fpga_io_pkg.
REQ-028 The per-channel pad buffer SHALL be the existing single-bit technology output buffer fpga_obuf, instantiated WIDTH times via generate; there SHALL be no vendor primitive directly in this module.
REQ-029 There SHALL be no other sub-modules.

Verification
REQ-030 WIDTH=8, SAFE_VAL=0xA5, HOLD_CYCLES=4: release reset with en=1 -> o=0xA5 and hold_busy=1 for exactly 4 cycles, then IDLE for 1 cycle, then active=1.
REQ-031 In ACTIVE with INV_MASK=0x0F, i=0x3C -> o=0x33 one cycle later.
REQ-032 freeze=1 with i stepping 0x01,0x02,0x03 -> o holds its prior value; freeze=0 -> o follows i with 1-cycle latency.
REQ-033 en dropped while freeze=1 -> o=SAFE_VAL on the next cycle and active=0.
REQ-034 rst pulsed asynchronously mid-ACTIVE, between clk edges -> o=SAFE_VAL before the next edge, and the HOLD count restarts from 0.
REQ-035 en toggled during HOLD -> no effect; ACTIVE is entered only via IDLE after HOLD_CYCLES.

Source files
------------

// File: rtl/fpga_io_pkg.sv
// Shared definitions for the FPGA pad-side I/O blocks: bank state encoding
// and the width of the post-reset hold counter.
package fpga_io_pkg;

    localparam int HOLD_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } io_state_t;

endpackage

// File: rtl/fpga_obuf.sv
// Single-bit technology output buffer. Behavioural stand-in for the
// vendor pad driver; the bank only ever instantiates it one bit at a time.
module fpga_obuf (
    input  logic i,
    output logic o
);

    assign o = i;

endmodule

// File: rtl/fpga_obuf_bank.sv
// Bank of output pads with a post-reset safe-hold window, enable-gated data
// path, freeze control and per-channel inversion. Pads are flop-driven only.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_HOLD   | post-reset hold, pads at SAFE_VAL, en ignored, counting
// ST_IDLE   | hold done, pads at SAFE_VAL, waiting for en
// ST_ACTIVE | pads follow i ^ INV_MASK one cycle late, freeze holds them
module fpga_obuf_bank
    import fpga_io_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               HOLD_CYCLES = 16,
    parameter logic [WIDTH-1:0] SAFE_VAL    = '0,
    parameter logic [WIDTH-1:0] INV_MASK    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    input  logic             en,
    input  logic             freeze,
    output logic [WIDTH-1:0] o,
    output logic             active,
    output logic             hold_busy
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_CNT_W-1:0] CNT_MAX   = '1;

    io_state_t             state;
    logic [HOLD_CNT_W-1:0] hold_cnt;
    logic [WIDTH-1:0]      o_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_HOLD;
            hold_cnt  <= '0;
            o_q       <= SAFE_VAL;
            active    <= 1'b0;
            hold_busy <= 1'b1;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state     <= ST_IDLE;
                        hold_busy <= 1'b0;
                    end else if (hold_cnt != CNT_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (en) begin
                        state  <= ST_ACTIVE;
                        active <= 1'b1;
                        if (!freeze) begin
                            o_q <= i ^ INV_MASK;
                        end
                    end
                end
                ST_ACTIVE: begin
                    // Dropping en wins over freeze so the pads never stay
                    // live after the request goes away.
                    if (!en) begin
                        state  <= ST_IDLE;
                        active <= 1'b0;
                        o_q    <= SAFE_VAL;
                    end else if (!freeze) begin
                        o_q <= i ^ INV_MASK;
                    end
                end
                default: begin
                    state     <= ST_HOLD;
                    hold_cnt  <= '0;
                    o_q       <= SAFE_VAL;
                    active    <= 1'b0;
                    hold_busy <= 1'b1;
                end
            endcase
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_pad
        fpga_obuf u_obuf (
            .i (o_q[g]),
            .o (o[g])
        );
    end

endmodule

// File: tb/tb_fpga_obuf_bank.sv
// Randomised and directed check of fpga_obuf_bank against a cycle-level
// behavioural model derived from edge counts since reset release.
module tb_fpga_obuf_bank;

    localparam int         WIDTH = 8;
    localparam int         HOLD  = 4;
    localparam logic [7:0] SAFE  = 8'hA5;
    localparam logic [7:0] INV   = 8'h0F;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       en;
    logic       freeze;
    logic [7:0] dout;
    logic       active;
    logic       hold_busy;

    int vectors;
    int miscompares;

    // model: edges seen since reset release, active flag, expected pads
    int         m_n;
    bit         m_act;
    logic [7:0] m_o;

    fpga_obuf_bank #(
        .WIDTH       (WIDTH),
        .HOLD_CYCLES (HOLD),
        .SAFE_VAL    (SAFE),
        .INV_MASK    (INV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i         (din),
        .en        (en),
        .freeze    (freeze),
        .o         (dout),
        .active    (active),
        .hold_busy (hold_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n   = 0;
        m_act = 1'b0;
        m_o   = SAFE;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (m_n < HOLD) begin
            m_n++;
        end else if (!m_act) begin
            if (en) begin
                m_act = 1'b1;
                if (!freeze) m_o = din ^ INV;
            end
        end else if (!en) begin
            m_act = 1'b0;
            m_o   = SAFE;
        end else if (!freeze) begin
            m_o = din ^ INV;
        end
    endtask

    task automatic compare_model();
        chk("o", 32'(dout), 32'(m_o));
        chk("active", 32'(active), 32'(m_act));
        chk("hold_busy", 32'(hold_busy), 32'(m_n < HOLD));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    // called 1 time unit after an edge; pulses rst well clear of both edges
    task automatic async_reset_pulse();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_o", 32'(dout), 32'(SAFE));
        chk("async_rst_active", 32'(active), 32'd0);
        chk("async_rst_hold_busy", 32'(hold_busy), 32'd1);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        din    = 8'h00;
        en     = 1'b1;
        freeze = 1'b0;
        model_reset();

        #22;
        rst = 1'b0;
        #1;
        chk("reset_o", 32'(dout), 32'(SAFE));
        chk("reset_hold_busy", 32'(hold_busy), 32'd1);
        chk("reset_active", 32'(active), 32'd0);

        // hold window with en already high: 3 more hold cycles, then idle
        for (int k = 1; k < HOLD; k++) begin
            cycle();
            chk("hold_busy_window", 32'(hold_busy), 32'd1);
            chk("hold_o", 32'(dout), 32'(SAFE));
        end
        din = 8'h3C;
        cycle();
        chk("idle_hold_busy", 32'(hold_busy), 32'd0);
        chk("idle_active", 32'(active), 32'd0);
        chk("idle_o", 32'(dout), 32'(SAFE));
        cycle();
        chk("enter_active", 32'(active), 32'd1);
        chk("inv_data", 32'(dout), 32'h33);

        freeze = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            din = 8'(k);
            cycle();
            chk("freeze_hold", 32'(dout), 32'h33);
        end
        freeze = 1'b0;
        cycle();
        chk("unfreeze_follow", 32'(dout), 32'h0C);

        en     = 1'b0;
        freeze = 1'b1;
        cycle();
        chk("drop_en_o", 32'(dout), 32'(SAFE));
        chk("drop_en_active", 32'(active), 32'd0);

        en     = 1'b1;
        freeze = 1'b0;
        din    = 8'h55;
        cycle();
        chk("reenter_o", 32'(dout), 32'h5A);

        async_reset_pulse();
        // en toggling during hold must not shorten or skip the window
        for (int k = 1; k < HOLD; k++) begin
            en = k[0];
            cycle();
            chk("hold_restart", 32'(hold_busy), 32'd1);
            chk("hold_restart_active", 32'(active), 32'd0);
        end
        en = 1'b1;
        cycle();
        chk("hold_restart_idle", 32'(active), 32'd0);
        cycle();
        chk("hold_restart_active_after", 32'(active), 32'd1);

        for (int n = 0; n < 600; n++) begin
            en     = ($urandom_range(0, 7) != 0);
            freeze = ($urandom_range(0, 3) == 0);
            din    = 8'($urandom);
            if ($urandom_range(0, 80) == 0) async_reset_pulse();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
